// File: rtl/bp_pkg.sv
// bp_pkg: shared counter encodings and mode constants for the branch predictor
package bp_pkg;
  typedef enum logic [1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11} ctr_t;
  localparam int PRED_STATIC  = 0;
  localparam int PRED_BIMODAL = 1;
  localparam ctr_t CTR_RST   = WNT;
  localparam ctr_t CTR_ALLOC = WT;
endpackage

// File: rtl/bp_sat_ctr2.sv
// bp_sat_ctr2: combinational 2-bit saturating counter next-state
module bp_sat_ctr2 import bp_pkg::*; (
  input  ctr_t i_ctr,
  input  logic i_taken,
  output ctr_t o_ctr
);
  always_comb
    o_ctr = i_taken ? ((i_ctr == ST) ? ST : ctr_t'(i_ctr + 2'd1))
                    : ((i_ctr == SNT) ? SNT : ctr_t'(i_ctr - 2'd1));
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit counters, fetch lookup and execute-side update
module branch_predictor import bp_pkg::*; #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int ENTRIES       = 16,
  parameter int PRED_MODE     = PRED_BIMODAL,
  parameter int STAT_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDRESS_WIDTH-1:0] pc_f,
  output logic                     pred_taken_f,
  output logic [ADDRESS_WIDTH-1:0] pred_next_pc_f,
  input  logic                     upd_valid_e,
  input  logic [ADDRESS_WIDTH-1:0] upd_pc_e,
  input  logic                     upd_is_branch_e,
  input  logic                     upd_taken_e,
  input  logic [ADDRESS_WIDTH-1:0] upd_target_e,
  input  logic                     pred_taken_e,
  input  logic [ADDRESS_WIDTH-1:0] pred_target_e,
  output logic                     mispredict_e,
  output logic [ADDRESS_WIDTH-1:0] redirect_pc_e,
  output logic [STAT_WIDTH-1:0]    branch_count,
  output logic [STAT_WIDTH-1:0]    mispredict_count
);
  localparam int AW    = ADDRESS_WIDTH;
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TW    = AW - IDX_W - 2;
  localparam bit MODE1 = (PRED_MODE == PRED_BIMODAL);
  logic             r_valid  [ENTRIES];
  logic [TW-1:0]    r_tag    [ENTRIES];
  logic [AW-1:0]    r_target [ENTRIES];
  ctr_t             r_ctr    [ENTRIES];
  logic [IDX_W-1:0] w_fidx, w_eidx;
  logic             w_fhit, w_ehit, w_branch;
  ctr_t             w_ctr_nxt;
  always_comb begin
    w_fidx         = pc_f[IDX_W+1:2];
    w_eidx         = upd_pc_e[IDX_W+1:2];
    w_fhit         = r_valid[w_fidx] && (r_tag[w_fidx] == pc_f[AW-1:IDX_W+2]);
    w_ehit         = r_valid[w_eidx] && (r_tag[w_eidx] == upd_pc_e[AW-1:IDX_W+2]);
    w_branch       = upd_valid_e && upd_is_branch_e;
    pred_taken_f   = MODE1 && w_fhit && (r_ctr[w_fidx] inside {WT, ST});
    pred_next_pc_f = pred_taken_f ? r_target[w_fidx] : pc_f + AW'(4);
    redirect_pc_e  = (upd_is_branch_e && upd_taken_e) ? upd_target_e : upd_pc_e + AW'(4);
    mispredict_e   = !MODE1 ? w_branch && upd_taken_e
                   : !upd_valid_e ? 1'b0
                   : upd_is_branch_e ? (pred_taken_e != upd_taken_e) ||
                                       (upd_taken_e && pred_target_e != upd_target_e)
                   : pred_taken_e;
  end
  bp_sat_ctr2 u_ctr (.i_ctr(r_ctr[w_eidx]), .i_taken(upd_taken_e), .o_ctr(w_ctr_nxt));
  // Table writes see pre-update contents on the fetch side until the next edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= CTR_RST;
      end
    end else if (MODE1 && upd_valid_e) begin
      if (upd_is_branch_e && w_ehit) begin
        r_ctr[w_eidx] <= w_ctr_nxt;
        if (upd_taken_e) r_target[w_eidx] <= upd_target_e;
      end else if (upd_is_branch_e && upd_taken_e) begin
        r_valid[w_eidx]  <= 1'b1;
        r_tag[w_eidx]    <= upd_pc_e[AW-1:IDX_W+2];
        r_target[w_eidx] <= upd_target_e;
        r_ctr[w_eidx]    <= CTR_ALLOC;
      end else if (!upd_is_branch_e && w_ehit) begin
        r_valid[w_eidx] <= 1'b0;
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      if (w_branch && !(&branch_count)) branch_count <= branch_count + 1'b1;
      if (mispredict_e && !(&mispredict_count)) mispredict_count <= mispredict_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: vector table with scoreboard queue, plus reset and static-mode sequences
module tb_branch_predictor;
  typedef struct packed {
    logic        ptk;
    logic [31:0] npc;
    logic        mis;
    logic [31:0] rdr;
  } exp_t;
  typedef struct packed {
    logic [31:0] pcf;
    logic        uv;
    logic [31:0] upc;
    logic        ub;
    logic        ut;
    logic [31:0] utg;
    logic        pt;
    logic [31:0] ptg;
    exp_t        e;
  } vec_t;
  logic        clk, rst;
  logic [31:0] pc_f, upd_pc_e, upd_target_e, pred_target_e;
  logic        upd_valid_e, upd_is_branch_e, upd_taken_e, pred_taken_e;
  logic        ptk, mis, m_ptk, m_mis;
  logic [31:0] npc, rdr, bcnt, mcnt, m_npc, m_rdr;
  logic [2:0]  m_bcnt, m_mcnt;
  int          nchk = 0, nerr = 0;
  exp_t        sb[$];
  vec_t        vt[23];
  branch_predictor dut (
    .clk(clk), .rst(rst), .pc_f(pc_f), .pred_taken_f(ptk), .pred_next_pc_f(npc),
    .upd_valid_e(upd_valid_e), .upd_pc_e(upd_pc_e), .upd_is_branch_e(upd_is_branch_e),
    .upd_taken_e(upd_taken_e), .upd_target_e(upd_target_e), .pred_taken_e(pred_taken_e),
    .pred_target_e(pred_target_e), .mispredict_e(mis), .redirect_pc_e(rdr),
    .branch_count(bcnt), .mispredict_count(mcnt));
  branch_predictor #(.PRED_MODE(0), .STAT_WIDTH(3)) dut_static (
    .clk(clk), .rst(rst), .pc_f(pc_f), .pred_taken_f(m_ptk), .pred_next_pc_f(m_npc),
    .upd_valid_e(upd_valid_e), .upd_pc_e(upd_pc_e), .upd_is_branch_e(upd_is_branch_e),
    .upd_taken_e(upd_taken_e), .upd_target_e(upd_target_e), .pred_taken_e(pred_taken_e),
    .pred_target_e(pred_target_e), .mispredict_e(m_mis), .redirect_pc_e(m_rdr),
    .branch_count(m_bcnt), .mispredict_count(m_mcnt));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic vec_t mk(logic [31:0] pcf, logic uv, logic [31:0] upc, logic ub, logic ut,
                              logic [31:0] utg, logic pt, logic [31:0] ptg,
                              logic eptk, logic [31:0] enpc, logic emis, logic [31:0] erdr);
    vec_t v;
    v.pcf = pcf; v.uv = uv; v.upc = upc; v.ub = ub; v.ut = ut; v.utg = utg; v.pt = pt; v.ptg = ptg;
    v.e.ptk = eptk; v.e.npc = enpc; v.e.mis = emis; v.e.rdr = erdr;
    return v;
  endfunction
  function automatic vec_t look(logic [31:0] pcf, logic eptk, logic [31:0] enpc);
    return mk(pcf, 0, 0, 0, 0, 0, 0, 0, eptk, enpc, 0, 32'h4);
  endfunction
  task automatic chk(string n, logic [31:0] act, logic [31:0] req);
    nchk++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s got=%h want=%h", n, act, req);
    end
  endtask
  task automatic drive(vec_t v);
    pc_f = v.pcf; upd_valid_e = v.uv; upd_pc_e = v.upc; upd_is_branch_e = v.ub;
    upd_taken_e = v.ut; upd_target_e = v.utg; pred_taken_e = v.pt; pred_target_e = v.ptg;
  endtask
  task automatic apply(int i);
    exp_t e;
    @(negedge clk);
    drive(vt[i]);
    sb.push_back(vt[i].e);
    #1;
    e = sb.pop_front();
    chk($sformatf("v%0d pred_taken", i), ptk, e.ptk);
    chk($sformatf("v%0d next_pc", i), npc, e.npc);
    chk($sformatf("v%0d mispredict", i), mis, e.mis);
    chk($sformatf("v%0d redirect", i), rdr, e.rdr);
  endtask
  initial begin
    vt[0]  = look(32'h100, 0, 32'h104);
    vt[1]  = mk(32'h40, 1, 32'h40, 1, 1, 32'h10, 0, 32'h44, 0, 32'h44, 1, 32'h10);
    vt[2]  = mk(32'h40, 1, 32'h40, 1, 1, 32'h10, 1, 32'h10, 1, 32'h10, 0, 32'h10);
    vt[3]  = mk(32'h40, 1, 32'h40, 1, 1, 32'h10, 1, 32'h10, 1, 32'h10, 0, 32'h10);
    vt[4]  = mk(32'h40, 1, 32'h40, 1, 0, 32'h10, 1, 32'h10, 1, 32'h10, 1, 32'h44);
    vt[5]  = mk(32'h40, 1, 32'h40, 1, 0, 32'h10, 1, 32'h10, 1, 32'h10, 1, 32'h44);
    vt[6]  = look(32'h40, 0, 32'h44);
    vt[7]  = look(32'h80, 0, 32'h84);
    vt[8]  = mk(32'h80, 1, 32'h80, 1, 1, 32'h400, 0, 32'h84, 0, 32'h84, 1, 32'h400);
    vt[9]  = look(32'h40, 0, 32'h44);
    vt[10] = look(32'h80, 1, 32'h400);
    vt[11] = mk(32'h200, 1, 32'h200, 1, 1, 32'h300, 0, 32'h204, 0, 32'h204, 1, 32'h300);
    vt[12] = mk(32'h200, 1, 32'h200, 1, 1, 32'h340, 1, 32'h300, 1, 32'h300, 1, 32'h340);
    vt[13] = look(32'h200, 1, 32'h340);
    vt[14] = mk(32'h200, 1, 32'h200, 0, 0, 32'h0, 1, 32'h340, 1, 32'h340, 1, 32'h204);
    vt[15] = look(32'h200, 0, 32'h204);
    vt[16] = mk(32'h84, 1, 32'h84, 1, 0, 32'h0, 0, 32'h88, 0, 32'h88, 0, 32'h88);
    vt[17] = look(32'h84, 0, 32'h88);
    vt[18] = mk(32'h84, 0, 32'h84, 1, 1, 32'h500, 0, 32'h88, 0, 32'h88, 0, 32'h500);
    vt[19] = look(32'h84, 0, 32'h88);
    vt[20] = mk(32'h84, 1, 32'h84, 1, 1, 32'h600, 0, 32'h88, 0, 32'h88, 1, 32'h600);
    vt[21] = look(32'h84, 1, 32'h600);
    vt[22] = look(32'h84, 1, 32'h600);
    rst = 1'b1;
    drive(vt[0]);
    #2 rst = 1'b0;
    #1;
    chk("reset pred_taken", ptk, 0);
    chk("reset branch_count", bcnt, 0);
    chk("reset mispredict_count", mcnt, 0);
    @(negedge clk) rst = 1'b1;
    for (int i = 0; i < 23; i++) apply(i);
    chk("branch_count", bcnt, 10);
    chk("mispredict_count", mcnt, 8);
    @(negedge clk);
    drive(mk(32'h84, 1, 32'h84, 1, 0, 32'h0, 1, 32'h600, 0, 0, 0, 0));
    #1 chk("pre-reset pred_taken", ptk, 1);
    #1 rst = 1'b0;
    #1;
    chk("async reset pred_taken", ptk, 0);
    chk("async reset next_pc", npc, 32'h88);
    chk("async reset branch_count", bcnt, 0);
    chk("async reset mispredict_count", mcnt, 0);
    @(negedge clk);
    upd_valid_e = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("post-reset pred_taken", ptk, 0);
    chk("post-reset branch_count", bcnt, 0);
    chk("static counts cleared", m_bcnt, 0);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      drive(mk(32'h40, 1, 32'h40, 1, 1, 32'h10, 0, 32'h44, 0, 0, 0, 0));
      #1;
      chk($sformatf("static%0d pred_taken", i), m_ptk, 0);
      chk($sformatf("static%0d next_pc", i), m_npc, 32'h44);
      chk($sformatf("static%0d mispredict", i), m_mis, 1);
      chk($sformatf("static%0d redirect", i), m_rdr, 32'h10);
    end
    @(negedge clk);
    upd_valid_e = 1'b0;
    #1;
    chk("static pred after training", m_ptk, 0);
    chk("static branch_count sat", m_bcnt, 7);
    chk("static mispredict_count sat", m_mcnt, 7);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
